// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES constants, FSM state type, inverse S-box and the
//             GF(2^8) helpers used by the iterative inverse cipher.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NR       = 10;
  localparam int BLOCK_W  = 128;
  localparam int RK_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_cipher_iter_if
//  Purpose  : Ciphertext-in / plaintext-out handshakes plus the round-key
//             store lookup bus of the iterative AES inverse cipher.
//  Revision : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_iter_if;
  import aes_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [BLOCK_W-1:0]  in_data;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [BLOCK_W-1:0]  rk_data;
  logic                out_valid;
  logic                out_ready;
  logic [BLOCK_W-1:0]  out_data;
  logic                busy;

  // Core side.
  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );

  // Environment side: upstream buffer, key store, downstream buffer.
  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_round
//  Purpose  : One combinational AES inverse round: InvShiftRows, InvSubBytes,
//             AddRoundKey, then InvMixColumns unless skip_mix is set (last
//             round).
//  Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] rk,
  input  logic               skip_mix,
  output logic [BLOCK_W-1:0] state_out
);

  // Byte k = 4*col+row sits at bits [127-8k -: 8].
  logic [7:0] ark [0:15];
  logic [7:0] mix [0:15];

  // InvShiftRows rotates row r right by r, so output (r,c) reads input
  // column (c-r) mod 4; the S-box lookup and key add follow per byte.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      localparam int DST = 4 * c + r;
      assign ark[DST] = INV_SBOX[state_in[BLOCK_W-1-8*SRC -: 8]]
                        ^ rk[BLOCK_W-1-8*DST -: 8];
    end
  end

  // InvMixColumns on each column of the key-added state.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix[4*c+0] = gf_mul0e(ark[4*c+0]) ^ gf_mul0b(ark[4*c+1])
                      ^ gf_mul0d(ark[4*c+2]) ^ gf_mul09(ark[4*c+3]);
    assign mix[4*c+1] = gf_mul09(ark[4*c+0]) ^ gf_mul0e(ark[4*c+1])
                      ^ gf_mul0b(ark[4*c+2]) ^ gf_mul0d(ark[4*c+3]);
    assign mix[4*c+2] = gf_mul0d(ark[4*c+0]) ^ gf_mul09(ark[4*c+1])
                      ^ gf_mul0e(ark[4*c+2]) ^ gf_mul0b(ark[4*c+3]);
    assign mix[4*c+3] = gf_mul0b(ark[4*c+0]) ^ gf_mul0d(ark[4*c+1])
                      ^ gf_mul09(ark[4*c+2]) ^ gf_mul0e(ark[4*c+3]);
  end

  for (genvar k = 0; k < 16; k++) begin : g_out
    assign state_out[BLOCK_W-1-8*k -: 8] = skip_mix ? ark[k] : mix[k];
  end

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_cipher_iter
//  Purpose  : Iterative AES-128 decryption, one inverse round per clock,
//             round keys fetched combinationally from an external store.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_cipher_iter_if.slave bus
);

  localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(NR);

  state_t              st, st_nxt;
  logic [RK_IDX_W-1:0] rnd;
  logic [BLOCK_W-1:0]  state_q;
  logic [BLOCK_W-1:0]  out_q;
  logic [BLOCK_W-1:0]  round_out;
  logic                skip_mix;
  logic                in_ready;
  logic                out_valid;
  logic                busy;
  logic [RK_IDX_W-1:0] rk_idx;

  aes_inv_round u_round (
    .state_in  (state_q),
    .rk        (bus.rk_data),
    .skip_mix  (skip_mix),
    .state_out (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next state and state-decoded outputs; outputs depend only on st/rnd.
  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = RK_LAST;
    skip_mix  = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) st_nxt = ROUND;
      end
      ROUND: begin
        rk_idx = rnd;
        if (rnd == RK_IDX_W'(1)) st_nxt = FINAL;
      end
      FINAL: begin
        rk_idx   = '0;
        skip_mix = 1'b1;
        st_nxt   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Datapath: initial key add on accept, one round per ROUND cycle,
  // capture of the plaintext in FINAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd     <= '0;
      state_q <= '0;
      out_q   <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= bus.in_data ^ bus.rk_data;
            rnd     <= RK_LAST - RK_IDX_W'(1);
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (rnd != RK_IDX_W'(1)) rnd <= rnd - RK_IDX_W'(1);
        end
        FINAL:   out_q <= round_out;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.rk_idx    = rk_idx;
  assign bus.out_data  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_inv_cipher_iter
//  Purpose  : Directed FIPS-197 vectors against aes_inv_cipher_iter with a
//             queue-based scoreboard and a decoupled output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;

  // Expanded schedule of key 000102030405060708090a0b0c0d0e0f.
  localparam logic [127:0] KEY_C [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };
  // Expanded schedule of key 2b7e151628aed2a6abf7158809cf4f3c.
  localparam logic [127:0] KEY_B [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk = 1'b0;
  logic rst_n;
  logic key_sel;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   received = 0;
  logic seen_valid = 1'b0;
  logic [127:0] exp_q [$];
  int           lat_q [$];

  aes_inv_cipher_iter_if bus ();

  aes_inv_cipher_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-key store: combinational lookup of the selected schedule.
  always_comb begin
    bus.rk_data = '0;
    if (int'(bus.rk_idx) <= 10)
      bus.rk_data = key_sel ? KEY_B[int'(bus.rk_idx)] : KEY_C[int'(bus.rk_idx)];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issue one block; the scoreboard entry is pushed at the accept edge.
  task automatic send(input logic [127:0] ct, input logic ks, input logic [127:0] pt,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 128'(0), 128'(1));
      acc = -1;
    end else begin
      key_sel = ks;
      acc = cyc;
      exp_q.push_back(pt);
      lat_q.push_back(cyc);
      @(posedge clk);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: latency on first out_valid, data compare on each transfer.
  initial begin
    logic [127:0] e;
    int a;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1) begin
        if (bus.out_valid && !seen_valid) begin
          seen_valid = 1'b1;
          if (lat_q.size() == 0) check("latency_unexpected", 128'(1), 128'(0));
          else begin
            a = lat_q.pop_front();
            check("latency", 128'(cyc - a), 128'(11));
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          seen_valid = 1'b0;
          received++;
          if (exp_q.size() == 0) check("output_unexpected", bus.out_data, 128'(0));
          else begin
            e = exp_q.pop_front();
            check("plaintext", bus.out_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, n;
    rst_n         = 1'b0;
    key_sel       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready",  128'(bus.in_ready),  128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_busy",      128'(bus.busy),      128'(0));
    check("reset_rk_idx",    128'(bus.rk_idx),    128'(10));
    check("reset_out_data",  bus.out_data,        128'(0));
    rst_n = 1'b1;

    // FIPS-197 C.1 with rk_idx sequence.
    @(negedge clk);
    check("idle_rk_idx", 128'(bus.rk_idx), 128'(10));
    send(C_CT, 1'b0, C_PT, acc1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("rk_idx_seq", 128'(bus.rk_idx), 128'(10 - i));
    end
    @(negedge clk);
    check("done_rk_idx",    128'(bus.rk_idx),    128'(10));
    check("done_out_valid", 128'(bus.out_valid), 128'(1));
    wait_drain();

    // FIPS-197 App. B.
    send(B_CT, 1'b1, B_PT, acc1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain();

    // Backpressure: 20 stalled cycles with an ignored new request.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(C_CT, 1'b0, C_PT, acc1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_reached_done", 128'(bus.out_valid), 128'(1));
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.in_data  = B_CT;
        bus.in_valid = 1'b1;
      end
      if (i == 10) bus.in_valid = 1'b0;
      check("stall_out_data",  bus.out_data,        C_PT);
      check("stall_in_ready",  128'(bus.in_ready),  128'(0));
      check("stall_out_valid", 128'(bus.out_valid), 128'(1));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_drain();
    send(B_CT, 1'b1, B_PT, acc1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain();

    // Back-to-back with in_valid and out_ready held high.
    send(C_CT, 1'b0, C_PT, acc1);
    send(B_CT, 1'b1, B_PT, acc2);
    check("b2b_spacing", 128'(acc2 - acc1), 128'(12));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain();

    // Reset while rk_idx == 5.
    send(C_CT, 1'b0, C_PT, acc1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_rk5", 128'(bus.rk_idx), 128'(5));
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    seen_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_busy",      128'(bus.busy),      128'(0));
    check("mid_rst_in_ready",  128'(bus.in_ready),  128'(1));
    check("mid_rst_rk_idx",    128'(bus.rk_idx),    128'(10));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(B_CT, 1'b1, B_PT, acc1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain();

    repeat (3) @(negedge clk);
    check("blocks_received", 128'(received), 128'(7));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 decryption core: accepts one 128-bit ciphertext block over a valid/ready handshake, applies the inverse cipher one round per clock using round keys fetched from an external round-key store, and returns the plaintext over a second valid/ready handshake. It is the decrypt-direction counterpart of the encrypt datapath. It sits between the block-level input buffer and the output buffer. It reuses the same byte ordering and round-key numbering as the encrypt path.

## Interface
- NR, 10, number of rounds (AES-128 only; other values unsupported)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext present on in_data
- in_ready  out  1  core idle and able to accept a block
- in_data  in  128  ciphertext; [127:120] = state byte s(0,0), column-major per FIPS-197
- rk_idx  out  4  index (0..10) of the round key requested this cycle
- rk_data  in  128  round key for rk_idx, valid combinationally in the same cycle
- out_valid  out  1  plaintext present on out_data
- out_ready  in  1  downstream accepts out_data
- out_data  out  128  plaintext, same byte order as in_data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. A 4-bit round counter rnd is used.
- IDLE:
  - in_ready=1, rk_idx=10.
  - On in_valid&&in_ready: state <= in_data ^ rk_data (AddRoundKey with rk[10]), rnd <= 9, go to ROUND.
- ROUND:
  - rk_idx=rnd.
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data)).
  - If rnd==1, go to FINAL. Otherwise rnd <= rnd-1.
- FINAL:
  - rk_idx=0.
  - out_data register <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data).
  - Go to DONE.
- DONE:
  - out_valid=1. out_data is held stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE.
  - rk_idx=10 in DONE.
- in_ready is high only in IDLE. in_valid in any other state is ignored and does not corrupt the in-flight block.
- InvMixColumns uses GF(2^8) multiplication by 0e/0b/0d/09 mod x^8+x^4+x^3+x+1. It is built from xtime chains, with no multipliers.
- InvSubBytes uses the inverse S-box as a 256-entry constant lookup, 16 instances.
- Reset, including mid-operation: asynchronous return to IDLE. State, out_data and rnd are cleared to 0. out_valid=0, busy=0, in_ready=1, rk_idx=10. Any partial block is discarded.

## Timing
- Accept handshake in cycle T leads to ROUND in cycles T+1..T+9 (rk_idx 9..1), FINAL in cycle T+10 (rk_idx 0), and out_valid=1 from cycle T+11.
- Latency from accept to first out_valid is 11 cycles.
- With out_ready held high, DONE lasts 1 cycle, IDLE is re-entered in T+12, and the next accept is possible in T+12. Throughput is one block per 12 cycles.
- Output stall: DONE persists indefinitely with out_data constant. in_ready stays 0 throughout.
- rk_idx is a pure function of FSM state and rnd, with no added latency. The key store must return rk_data in the same cycle.
- No combinational path from in_valid or out_ready to any output other than the FSM next-state.

## Structure
- Shared package aes_pkg holds:
  - NR, BLOCK_W=128, RK_IDX_W=4
  - FSM state enum
  - inverse S-box constant array
  - gf_xtime function and gf_mul 09/0b/0d/0e functions
- One sub-module, aes_inv_round: combinational InvShiftRows, then InvSubBytes, then AddRoundKey, then optional InvMixColumns.
  - A skip_mix input selects the FINAL path, so a single instance serves ROUND and FINAL.
- The top level contains only the FSM, rnd, the state and out_data registers, and the handshake logic.

## Test plan
- FIPS-197 C.1:
  - Stimulus: ct 69c4e0d86a7b0430d8cdb78070b4c55a, with round keys from key 000102030405060708090a0b0c0d0e0f.
  - Required: out_data 00112233445566778899aabbccddeeff, out_valid first seen exactly 11 cycles after accept.
  - Required: rk_idx sequence 10,9,…,1,0.
- FIPS-197 App. B:
  - Stimulus: ct 3925841d02dc09fbdc118597196a0b32, with round keys from key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: out_data 3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_data stable, in_ready=0. A new in_valid with a different ct is ignored.
  - Required: after out_ready, the next block decrypts correctly.
- Back-to-back:
  - Stimulus: both vectors with in_valid and out_ready always high.
  - Required: accepts 12 cycles apart, both results correct and in order.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while rk_idx=5.
  - Required: outputs take their reset values immediately (out_valid=0, busy=0, in_ready=1, rk_idx=10).
  - Required: the next block after reset release decrypts correctly.
